// File: rtl/pc_one_pkg.sv
// Shared definitions for the pc-one core front end.
package pc_one_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One fetched instruction paired with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding fetched {pc, instr} pairs between the ROM and decode.
module fetch_skid_buf
    import pc_one_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // Occupancy and pointers; flush wins over a simultaneous push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Entry storage carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues ROM reads, absorbs the one-cycle read
// latency and hands {pc, instr} to decode over valid/ready.
module fetch_unit
    import pc_one_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic                clk,
    input  logic                rst,
    output logic [XLEN-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [INSTR_W-1:0]  out_instr
);

    logic [XLEN-1:0] fetch_pc;
    logic            inflight_v;
    logic [XLEN-1:0] inflight_pc;

    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    arrival;
    logic            pop;
    logic            push;
    logic            issue;
    logic [2:0]      occupancy;

    assign pop = out_valid && out_ready;

    // Space after this cycle: buffered + in flight - leaving. A new read is
    // only started when its data is guaranteed a slot two cycles from now.
    assign occupancy = {1'b0, count} + {2'b00, inflight_v} - {2'b00, pop};

    // Issue/redirect decision and the address presented to the ROM.
    always_comb begin
        issue     = (occupancy <= 3'd1);
        imem_addr = fetch_pc;
        if (redirect_valid) begin
            issue     = 1'b1;
            imem_addr = align_pc(redirect_pc);
        end
    end

    // A redirect discards whatever the ROM is returning this cycle.
    assign push          = inflight_v && !redirect_valid;
    assign arrival.pc    = inflight_pc;
    assign arrival.instr = imem_rdata;

    // Fetch pointer and the single outstanding ROM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            inflight_v <= issue;
            if (issue) begin
                inflight_pc <= imem_addr;
                fetch_pc    <= imem_addr + PC_STEP;
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (arrival),
        .head      (head),
        .count     (count)
    );

    // Head of the buffer is presented to decode; zeroed when empty so the
    // outputs read 0 out of reset without resetting the data storage.
    assign out_valid = (count != 2'd0);
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a one-cycle-latency ROM model.
module tb_fetch_unit;

    localparam logic [31:0] ROM_OFS = 32'h1000_0000;
    localparam int          SB_FILL = 64;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int err_cnt = 0;
    int chk_cnt = 0;
    int pop_cnt = 0;

    logic [31:0] sb_q [$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: word at A is A + 0x1000_0000, returned one cycle after sampling.
    always @(posedge clk) imem_rdata <= imem_addr + ROM_OFS;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic sb_load(input logic [31:0] base);
        logic [31:0] pc;
        sb_q.delete();
        pc = base & ~32'd3;
        for (int i = 0; i < SB_FILL; i++) begin
            sb_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endtask

    // Scoreboard: every completed handshake must match the next expected PC;
    // reset and redirects restart the expected stream.
    always @(negedge clk) begin
        if (rst) begin
            sb_load(32'h0);
        end else begin
            if (out_valid && out_ready) begin
                logic [31:0] exp_pc;
                pop_cnt++;
                check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_pc = sb_q.pop_front();
                    check_eq("sb_pc", out_pc, exp_pc);
                    check_eq("sb_instr", out_instr, exp_pc + ROM_OFS);
                end
            end
            if (redirect_valid) sb_load(redirect_pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_pc",    out_pc,    32'h0);
        check_eq("rst_instr", out_instr, 32'h0);
        check_eq("rst_addr",  imem_addr, 32'h0);

        // Streaming with out_ready high
        rst = 1'b0;
        tick();
        check_eq("lat1_valid", 32'(out_valid), 32'd0);
        tick();
        check_eq("lat2_valid", 32'(out_valid), 32'd1);
        check_eq("lat2_pc",    out_pc,    32'h0);
        check_eq("lat2_instr", out_instr, 32'h1000_0000);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq("stream_valid", 32'(out_valid), 32'd1);
            check_eq("stream_pc",    out_pc, 32'(i * 4));
        end

        // Back-pressure right after the first valid
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_eq("stall_first_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_pc",   out_pc,    32'h0);
            check_eq("stall_addr", imem_addr, 32'h8);
            tick();
        end
        p0 = pop_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("release_valid", 32'(out_valid), 32'd1);
        end
        check_eq("release_pops", 32'(pop_cnt - p0), 32'd4);

        // Redirect while the buffer is full
        out_ready = 1'b0;
        repeat (3) tick();
        check_eq("full_valid", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        check_eq("redir_addr", imem_addr, 32'h100);
        tick();
        redirect_valid = 1'b0;
        check_eq("redir_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        check_eq("redir_lat2_valid", 32'(out_valid), 32'd1);
        check_eq("redir_pc",    out_pc,    32'h100);
        check_eq("redir_instr", out_instr, 32'h1000_0100);
        out_ready = 1'b1;
        repeat (4) tick();

        // Two redirects on consecutive cycles
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        check_eq("b2b_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        check_eq("b2b_pc", out_pc, 32'h80);
        repeat (4) tick();

        // Address wrap-around
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_eq("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        tick();
        check_eq("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_pc2", out_pc, 32'h0000_0000);
        repeat (2) tick();

        // Asynchronous reset mid-stream
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_valid", 32'(out_valid), 32'd0);
        check_eq("async_pc",    out_pc,    32'h0);
        check_eq("async_instr", out_instr, 32'h0);
        check_eq("async_addr",  imem_addr, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("rerst_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        check_eq("rerst_valid", 32'(out_valid), 32'd1);
        check_eq("rerst_pc",    out_pc, 32'h0);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
